// File: rtl/rt_ibex_register_window_spill.sv
// Banked register windows for nested interrupts, with oldest-window spill
// to memory on push and refill on mret when no window is left on chip.
module rt_ibex_register_window_spill #(
   parameter int DataWidth  = 32,
   parameter int NumWindows = 4,
   parameter int WindowSize = 7,
   parameter int MaxDepth   = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [4:0]                   raddr_a_i,
   input  logic [4:0]                   raddr_b_i,
   output logic [DataWidth-1:0]         rdata_a_o,
   output logic [DataWidth-1:0]         rdata_b_o,
   input  logic [4:0]                   waddr_a_i,
   input  logic [DataWidth-1:0]         wdata_a_i,
   input  logic                         we_a_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [31:0]                  mcause_i,
   input  logic [31:0]                  mepc_i,
   output logic [31:0]                  mcause_o,
   output logic [31:0]                  mepc_o,
   output logic                         busy_o,
   output logic [$clog2(MaxDepth+1)-1:0] depth_o,
   output logic                         overflow_o,
   input  logic [31:0]                  spill_base_i,
   output logic                         mem_req_o,
   output logic                         mem_we_o,
   output logic [31:0]                  mem_addr_o,
   output logic [DataWidth-1:0]         mem_wdata_o,
   input  logic                         mem_gnt_i,
   input  logic                         mem_rvalid_i,
   input  logic [DataWidth-1:0]         mem_rdata_i
);

   localparam int FW = WindowSize + 2;
   localparam int DW = $clog2(MaxDepth + 1);
   localparam int RW = $clog2(NumWindows + 1);
   localparam int SW = $clog2(NumWindows);
   localparam int KW = $clog2(FW);
   localparam int OW = $clog2(WindowSize);

   typedef enum logic [1:0] {IDLE, SPILL, FILL} state_e;

   state_e                state_q, state_d;
   logic [DW-1:0]         depth_q, depth_d;
   logic [RW-1:0]         resident_q, resident_d;
   logic [KW-1:0]         k_q, k_d;
   logic [SW-1:0]         xslot_q, xslot_d;
   logic [DW-1:0]         frame_q, frame_d;
   logic                  wait_q, wait_d;
   logic                  busy_q, busy_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [31:0]           addr_q, addr_d;
   logic [DataWidth-1:0]  wdata_q, wdata_d;
   logic                  ovf_q, ovf_d;
   logic [31:0]           pcause_q, pcause_d;
   logic [31:0]           pepc_q, pepc_d;

   logic [DataWidth-1:0]  base_rf  [32];
   logic [DataWidth-1:0]  win_rf   [NumWindows][WindowSize];
   logic [31:0]           cause_rf [NumWindows];
   logic [31:0]           epc_rf   [NumWindows];

   logic                  rf_we, win_we, cause_we, epc_we;
   logic [SW-1:0]         win_slot, csr_slot;
   logic [OW-1:0]         win_off_w;
   logic [DataWidth-1:0]  win_data;
   logic [31:0]           cause_data, epc_data;

   logic [SW-1:0]         cur_slot, new_slot, sel_slot;
   logic [KW-1:0]         sel_k;
   logic [DataWidth-1:0]  sel_word;
   logic [DW-1:0]         spilled;

   function automatic int win_idx(input logic [4:0] a);
      case (a)
         5'd1:    return 0;
         5'd5:    return 1;
         5'd10:   return 2;
         5'd11:   return 3;
         5'd12:   return 4;
         5'd13:   return 5;
         5'd15:   return 6;
         default: return -1;
      endcase
   endfunction

   function automatic logic win_hit(input logic [4:0] a);
      int m;
      m = win_idx(a);
      return (m >= 0) && (m < WindowSize);
   endfunction

   function automatic logic [OW-1:0] win_off(input logic [4:0] a);
      return OW'(win_idx(a));
   endfunction

   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [DW-1:0] n,
                                             input logic [KW-1:0] k);
      return base + ((32'(n) * 32'(FW) + 32'(k)) << 2);
   endfunction

   function automatic logic [DataWidth-1:0] rd_port(input logic [4:0] a);
      logic [DataWidth-1:0] v;
      v = '0;
      if (a != '0) v = base_rf[a];
      if (win_hit(a) && depth_q != '0) v = win_rf[cur_slot][win_off(a)];
      return v;
   endfunction

   assign cur_slot = SW'(depth_q - DW'(1));
   assign new_slot = SW'(depth_q);
   assign spilled  = depth_q - DW'(resident_q);

   always_comb begin
      rdata_a_o = rd_port(raddr_a_i);
      rdata_b_o = rd_port(raddr_b_i);
   end

   always_comb begin
      mcause_o = '0;
      mepc_o   = '0;
      if (depth_q != '0) begin
         mcause_o = cause_rf[cur_slot];
         mepc_o   = epc_rf[cur_slot];
      end
   end

   // Next outgoing spill word: word 0 of the oldest slot when starting.
   always_comb begin
      sel_slot = xslot_q;
      sel_k    = k_q + KW'(1);
      if (state_q == IDLE) begin
         sel_slot = new_slot;
         sel_k    = '0;
      end
      sel_word = DataWidth'(epc_rf[sel_slot]);
      if (sel_k < KW'(WindowSize))
         sel_word = win_rf[sel_slot][sel_k[OW-1:0]];
      else if (sel_k == KW'(WindowSize))
         sel_word = DataWidth'(cause_rf[sel_slot]);
   end

   always_comb begin
      state_d    = state_q;
      depth_d    = depth_q;
      resident_d = resident_q;
      k_d        = k_q;
      xslot_d    = xslot_q;
      frame_d    = frame_q;
      wait_d     = wait_q;
      busy_d     = busy_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ovf_d      = ovf_q;
      pcause_d   = pcause_q;
      pepc_d     = pepc_q;
      rf_we      = 1'b0;
      win_we     = 1'b0;
      win_slot   = cur_slot;
      win_off_w  = win_off(waddr_a_i);
      win_data   = wdata_a_i;
      cause_we   = 1'b0;
      epc_we     = 1'b0;
      csr_slot   = cur_slot;
      cause_data = mcause_i;
      epc_data   = mepc_i;
      unique case (state_q)
         IDLE: begin
            if (we_a_i) begin
               if (win_hit(waddr_a_i) && depth_q != '0) win_we = 1'b1;
               else if (waddr_a_i != '0) rf_we = 1'b1;
            end
            if (push_i && pop_i && depth_q != '0) begin
               cause_we = 1'b1;
               epc_we   = 1'b1;
            end else if (pop_i) begin
               if (depth_q == '0) begin
                  ovf_d = 1'b1;
               end else begin
                  depth_d    = depth_q - DW'(1);
                  resident_d = resident_q - RW'(1);
                  // Last resident window leaving while older frames sit in memory.
                  if (resident_q == RW'(1) && depth_q != DW'(1)) begin
                     state_d = FILL;
                     busy_d  = 1'b1;
                     req_d   = 1'b1;
                     we_d    = 1'b0;
                     k_d     = '0;
                     wait_d  = 1'b0;
                     frame_d = spilled - DW'(1);
                     xslot_d = SW'(spilled - DW'(1));
                     addr_d  = word_addr(spill_base_i, spilled - DW'(1), '0);
                  end
               end
            end else if (push_i) begin
               if (depth_q == DW'(MaxDepth)) begin
                  ovf_d = 1'b1;
               end else if (resident_q == RW'(NumWindows)) begin
                  state_d  = SPILL;
                  busy_d   = 1'b1;
                  req_d    = 1'b1;
                  we_d     = 1'b1;
                  k_d      = '0;
                  frame_d  = spilled;
                  xslot_d  = new_slot;
                  addr_d   = word_addr(spill_base_i, spilled, '0);
                  wdata_d  = sel_word;
                  pcause_d = mcause_i;
                  pepc_d   = mepc_i;
               end else begin
                  depth_d    = depth_q + DW'(1);
                  resident_d = resident_q + RW'(1);
                  cause_we   = 1'b1;
                  epc_we     = 1'b1;
                  csr_slot   = new_slot;
               end
            end
         end
         SPILL: begin
            if (req_q && mem_gnt_i) begin
               if (k_q == KW'(FW - 1)) begin
                  state_d    = IDLE;
                  busy_d     = 1'b0;
                  req_d      = 1'b0;
                  we_d       = 1'b0;
                  depth_d    = depth_q + DW'(1);
                  cause_we   = 1'b1;
                  epc_we     = 1'b1;
                  csr_slot   = xslot_q;
                  cause_data = pcause_q;
                  epc_data   = pepc_q;
               end else begin
                  k_d     = k_q + KW'(1);
                  addr_d  = word_addr(spill_base_i, frame_q, k_q + KW'(1));
                  wdata_d = sel_word;
               end
            end
         end
         FILL: begin
            if (req_q) begin
               if (mem_gnt_i) begin
                  req_d  = 1'b0;
                  wait_d = 1'b1;
               end
            end else if (wait_q && mem_rvalid_i) begin
               wait_d = 1'b0;
               if (k_q < KW'(WindowSize)) begin
                  win_we    = 1'b1;
                  win_slot  = xslot_q;
                  win_off_w = k_q[OW-1:0];
                  win_data  = mem_rdata_i;
               end else if (k_q == KW'(WindowSize)) begin
                  cause_we   = 1'b1;
                  csr_slot   = xslot_q;
                  cause_data = 32'(mem_rdata_i);
               end else begin
                  epc_we   = 1'b1;
                  csr_slot = xslot_q;
                  epc_data = 32'(mem_rdata_i);
               end
               if (k_q == KW'(FW - 1)) begin
                  state_d    = IDLE;
                  busy_d     = 1'b0;
                  resident_d = RW'(1);
               end else begin
                  k_d    = k_q + KW'(1);
                  req_d  = 1'b1;
                  addr_d = word_addr(spill_base_i, frame_q, k_q + KW'(1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         depth_q    <= '0;
         resident_q <= '0;
         k_q        <= '0;
         xslot_q    <= '0;
         frame_q    <= '0;
         wait_q     <= 1'b0;
         busy_q     <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ovf_q      <= 1'b0;
         pcause_q   <= '0;
         pepc_q     <= '0;
      end else begin
         state_q    <= state_d;
         depth_q    <= depth_d;
         resident_q <= resident_d;
         k_q        <= k_d;
         xslot_q    <= xslot_d;
         frame_q    <= frame_d;
         wait_q     <= wait_d;
         busy_q     <= busy_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ovf_q      <= ovf_d;
         pcause_q   <= pcause_d;
         pepc_q     <= pepc_d;
      end
   end

   // Register and window contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (rf_we) base_rf[waddr_a_i] <= wdata_a_i;
         if (win_we) win_rf[win_slot][win_off_w] <= win_data;
         if (cause_we) cause_rf[csr_slot] <= cause_data;
         if (epc_we) epc_rf[csr_slot] <= epc_data;
      end
   end

   assign busy_o      = busy_q;
   assign depth_o     = depth_q;
   assign overflow_o  = ovf_q;
   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_rt_ibex_register_window_spill.sv
// Directed bench for the register window spill unit with a small
// memory responder whose grant latency can be varied.
module tb_rt_ibex_register_window_spill;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  raddr_a_i, raddr_b_i, waddr_a_i;
   logic [31:0] rdata_a_o, rdata_b_o, wdata_a_i;
   logic        we_a_i, push_i, pop_i;
   logic [31:0] mcause_i, mepc_i, mcause_o, mepc_o;
   logic        busy_o, overflow_o;
   logic [4:0]  depth_o;
   logic [31:0] spill_base_i;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int total = 0;
   int bad = 0;

   logic [31:0] mem [0:255];
   int gnt_dly = 0;
   int wcnt = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int req_cycles = 0;
   int stab_err = 0;
   logic rd_pend = 1'b0;
   int rd_idx = 0;
   logic hold_v = 1'b0;
   logic [31:0] hold_a, hold_d;
   logic hold_we;
   logic [4:0] wa [7];
   int bc;

   always #5 clk_i = ~clk_i;

   rt_ibex_register_window_spill dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
      .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
      .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i), .we_a_i(we_a_i),
      .push_i(push_i), .pop_i(pop_i),
      .mcause_i(mcause_i), .mepc_i(mepc_i),
      .mcause_o(mcause_o), .mepc_o(mepc_o),
      .busy_o(busy_o), .depth_o(depth_o), .overflow_o(overflow_o),
      .spill_base_i(spill_base_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i)
   );

   function automatic int midx(input logic [31:0] a);
      return int'(((a - BASE) >> 2) & 32'hff);
   endfunction

   function automatic logic [31:0] epc(input int i);
      return 32'h8000_0000 + 32'(4 * i);
   endfunction

   // Accept side: record words at the granting edge, track stability.
   always @(posedge clk_i) begin
      if (mem_req_o) begin
         req_cycles++;
         if (hold_v && (mem_addr_o !== hold_a || mem_wdata_o !== hold_d ||
                        mem_we_o !== hold_we))
            stab_err++;
         hold_v  = !mem_gnt_i;
         hold_a  = mem_addr_o;
         hold_d  = mem_wdata_o;
         hold_we = mem_we_o;
         if (mem_gnt_i) begin
            if (mem_we_o) begin
               mem[midx(mem_addr_o)] = mem_wdata_o;
               wr_cnt++;
            end else begin
               rd_pend = 1'b1;
               rd_idx  = midx(mem_addr_o);
               rd_cnt++;
            end
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   always @(negedge clk_i) begin
      mem_rvalid_i = rd_pend;
      if (rd_pend) mem_rdata_i = mem[rd_idx];
      rd_pend   = 1'b0;
      mem_gnt_i = 1'b0;
      if (mem_req_o) begin
         if (wcnt >= gnt_dly) begin
            mem_gnt_i = 1'b1;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy_o && cyc < 500) begin
         tick();
         cyc++;
      end
      chk("idle_timeout", 32'(busy_o), 32'd0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we_a_i = 1'b1;
      waddr_a_i = a;
      wdata_a_i = d;
      tick();
      we_a_i = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] a,
                          input logic [31:0] exp);
      raddr_a_i = a;
      #1;
      chk(tag, rdata_a_o, exp);
   endtask

   task automatic do_push(input int c, input logic [31:0] e, output int cyc);
      push_i = 1'b1;
      mcause_i = 32'(c);
      mepc_i = e;
      tick();
      push_i = 1'b0;
      wait_idle(cyc);
   endtask

   task automatic do_pop(output int cyc);
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
      wait_idle(cyc);
   endtask

   task automatic fill_level(input int lvl, input logic [31:0] salt);
      for (int o = 0; o < 7; o++)
         wr(wa[o], salt + 32'(32'h100 * lvl) + 32'(o));
   endtask

   initial begin
      wa = '{5'd1, 5'd5, 5'd10, 5'd11, 5'd12, 5'd13, 5'd15};
      rst_i = 1'b1;
      push_i = 1'b0; pop_i = 1'b0; we_a_i = 1'b0;
      waddr_a_i = '0; wdata_a_i = '0;
      raddr_a_i = '0; raddr_b_i = '0;
      mcause_i = '0; mepc_i = '0;
      spill_base_i = BASE;
      repeat (2) tick();
      rst_i = 1'b0;
      tick();
      chk("rst_depth", 32'(depth_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_ovf", 32'(overflow_o), 32'd0);
      chk("rst_mcause", mcause_o, 32'd0);
      chk("rst_mepc", mepc_o, 32'd0);

      wr(5'd10, 32'hA);
      wr(5'd2, 32'h22);
      wr(5'd0, 32'h55);
      chk_reg("x10_d0", 5'd10, 32'hA);
      chk_reg("x0_zero", 5'd0, 32'd0);
      do_push(1, epc(1), bc);
      chk("push1_depth", 32'(depth_o), 32'd1);
      chk("push1_mcause", mcause_o, 32'd1);
      chk("push1_mepc", mepc_o, epc(1));
      wr(5'd10, 32'hB);
      chk_reg("x10_d1", 5'd10, 32'hB);
      raddr_b_i = 5'd2;
      #1;
      chk("x2_d1_base", rdata_b_o, 32'h22);
      do_pop(bc);
      chk("pop1_depth", 32'(depth_o), 32'd0);
      chk_reg("x10_back", 5'd10, 32'hA);
      chk("pop1_mcause", mcause_o, 32'd0);
      chk("no_mem_traffic", 32'(req_cycles), 32'd0);

      gnt_dly = 0;
      for (int i = 1; i <= 4; i++) begin
         do_push(i, epc(i), bc);
         fill_level(i, 32'h0);
      end
      chk("d4_depth", 32'(depth_o), 32'd4);
      chk("d4_no_wr", 32'(wr_cnt), 32'd0);
      do_push(5, epc(5), bc);
      chk("spill_busy_len", 32'(bc >= 9), 32'd1);
      chk("spill_wr_cnt", 32'(wr_cnt), 32'd9);
      chk("spill_w0", mem[0], 32'h100);
      chk("spill_w2", mem[2], 32'h102);
      chk("spill_w6", mem[6], 32'h106);
      chk("spill_cause", mem[7], 32'd1);
      chk("spill_epc", mem[8], epc(1));
      chk("spill_depth", 32'(depth_o), 32'd5);
      chk("spill_mcause", mcause_o, 32'd5);
      chk("spill_mepc", mepc_o, epc(5));
      fill_level(5, 32'h0);
      chk_reg("x10_d5", 5'd10, 32'h502);

      do_pop(bc);
      chk("pop_d4", 32'(depth_o), 32'd4);
      chk("pop_d4_mcause", mcause_o, 32'd4);
      chk_reg("pop_d4_x10", 5'd10, 32'h402);
      do_pop(bc);
      do_pop(bc);
      chk("pop_d2_mcause", mcause_o, 32'd2);
      chk("pop_no_rd", 32'(rd_cnt), 32'd0);
      do_pop(bc);
      chk("fill_rd_cnt", 32'(rd_cnt), 32'd9);
      chk("fill_depth", 32'(depth_o), 32'd1);
      chk("fill_mcause", mcause_o, 32'd1);
      chk("fill_mepc", mepc_o, epc(1));
      chk_reg("fill_x10", 5'd10, 32'h102);
      chk_reg("fill_x1", 5'd1, 32'h100);
      chk_reg("fill_x15", 5'd15, 32'h106);
      do_pop(bc);
      chk("pop_d0", 32'(depth_o), 32'd0);
      chk_reg("pop_d0_x10", 5'd10, 32'hA);

      gnt_dly = 3;
      wr_cnt = 0;
      stab_err = 0;
      for (int i = 1; i <= 4; i++) begin
         do_push(i, epc(i), bc);
         fill_level(i, 32'h10000);
      end
      do_push(5, epc(5), bc);
      chk("slow_busy_len", 32'(bc >= 36), 32'd1);
      chk("slow_wr_cnt", 32'(wr_cnt), 32'd9);
      chk("slow_stable", 32'(stab_err), 32'd0);
      chk("slow_w0", mem[0], 32'h10100);
      chk("slow_w4", mem[4], 32'h10104);
      chk("slow_cause", mem[7], 32'd1);
      chk("slow_epc", mem[8], epc(1));

      push_i = 1'b1;
      mcause_i = 32'd6;
      mepc_i = epc(6);
      tick();
      push_i = 1'b0;
      tick();
      chk("mid_busy", 32'(busy_o), 32'd1);
      chk("mid_req", 32'(mem_req_o), 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("abort_req", 32'(mem_req_o), 32'd0);
      chk("abort_depth", 32'(depth_o), 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_mcause", mcause_o, 32'd0);
      tick();

      gnt_dly = 0;
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
      chk("uf_ovf", 32'(overflow_o), 32'd1);
      chk("uf_depth", 32'(depth_o), 32'd0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("ovf_clr", 32'(overflow_o), 32'd0);

      wr_cnt = 0;
      for (int i = 1; i <= 16; i++) do_push(i, epc(i), bc);
      chk("max_depth", 32'(depth_o), 32'd16);
      chk("max_ovf0", 32'(overflow_o), 32'd0);
      chk("max_wr_cnt", 32'(wr_cnt), 32'd108);
      chk("max_mcause", mcause_o, 32'd16);
      push_i = 1'b1;
      tick();
      push_i = 1'b0;
      chk("of_ovf", 32'(overflow_o), 32'd1);
      chk("of_depth", 32'(depth_o), 32'd16);
      chk("of_busy", 32'(busy_o), 32'd0);
      rd_cnt = 0;
      push_i = 1'b1;
      pop_i = 1'b1;
      mcause_i = 32'h77;
      mepc_i = 32'h7700;
      tick();
      push_i = 1'b0;
      pop_i = 1'b0;
      tick();
      chk("pp_depth", 32'(depth_o), 32'd16);
      chk("pp_mcause", mcause_o, 32'h77);
      chk("pp_mepc", mepc_o, 32'h7700);
      chk("pp_busy", 32'(busy_o), 32'd0);
      chk("pp_no_wr", 32'(wr_cnt), 32'd108);
      chk("pp_no_rd", 32'(rd_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
